// File: rtl/battleship_pkg.sv
// battleship_pkg
// Shared types and defaults for the attacking side of the battleship game.
//   state_t   : shooter controller states
//   dir_t     : neighbour order tried around an anchor hit (east, west, south, north)
//   verdict_t : responder verdict after hit > nearmiss > miss priority
//   decode_verdict : collapses the three verdict bits into a verdict_t
package battleship_pkg;

  localparam int DEFAULT_GRID_W      = 10;
  localparam int DEFAULT_GRID_H      = 10;
  localparam int DEFAULT_TARGET_HITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    FIRE,
    WAIT,
    TARGET,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    EAST,
    WEST,
    SOUTH,
    NORTH
  } dir_t;

  typedef enum logic [1:0] {
    V_HIT,
    V_NEAR,
    V_MISS
  } verdict_t;

  // A verdict with no bit set still means the shot landed in open water,
  // so every path that is not a hit or a nearmiss collapses to a miss.
  function automatic verdict_t decode_verdict(input logic hit,
                                              input logic nearmiss,
                                              input logic miss);
    verdict_t v;
    v = V_MISS;
    if (hit) begin
      v = V_HIT;
    end else if (nearmiss) begin
      v = V_NEAR;
    end else if (miss) begin
      v = V_MISS;
    end
    return v;
  endfunction

endpackage

// File: rtl/battleship_shooter_bitmap.sv
// shot_bitmap
// One bit per grid cell remembering which cells have already been fired on.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset (clears all)
//   clear          : clear every bit (new game)
//   set_en         : mark cell (set_x, set_y) as shot
//   set_x, set_y   : on-grid coordinate being marked
//   query_x/query_y: coordinate being asked about; may be off-grid
//   query_shot     : 1 when the queried cell is on-grid and already shot
module shot_bitmap #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       set_en,
  input  logic [3:0] set_x,
  input  logic [3:0] set_y,
  input  logic [4:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_shot
);

  localparam int         NCELL = GRID_W * GRID_H;
  localparam int         IW    = $clog2(NCELL);
  localparam logic [4:0] GW    = 5'(GRID_W);
  localparam logic [4:0] GH    = 5'(GRID_H);

  logic [NCELL-1:0] bits;
  logic [IW-1:0]    set_idx;
  logic [IW-1:0]    query_idx;
  logic             query_on_grid;

  // Row-major cell index. Off-grid queries may alias onto a real cell, so the
  // lookup result is masked by the on-grid test rather than trusted directly.
  always_comb begin
    set_idx       = IW'(set_y) * IW'(GRID_W) + IW'(set_x);
    query_idx     = IW'(query_y) * IW'(GRID_W) + IW'(query_x);
    query_on_grid = (query_x < GW) && (query_y < GH);
    query_shot    = query_on_grid && bits[query_idx];
  end

  // Clearing wins over marking; the controller never asks for both at once
  // because a new game only starts while no shot is outstanding.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      bits <= '0;
    end else if (set_en) begin
      bits[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/battleship_shooter.sv
// battleship_shooter
// Chooses shots against a boat responder: checkerboard hunt in row-major
// order, then east/west/south/north probing around a hit until the boat is
// finished, never firing twice on the same cell.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   start                : begin a game (only from IDLE or DONE)
//   x, y, shot_valid     : shot request, coordinates stable while valid
//   result_valid         : responder verdict present this cycle
//   hit, nearmiss, miss  : verdict bits, priority hit > nearmiss > miss
//   done                 : game over, sticky until restart or reset
//   shot_count, hit_count, near_count : saturating tallies of accepted verdicts
module battleship_shooter
  import battleship_pkg::*;
#(
  parameter int GRID_W      = DEFAULT_GRID_W,
  parameter int GRID_H      = DEFAULT_GRID_H,
  parameter int TARGET_HITS = DEFAULT_TARGET_HITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       shot_valid,
  input  logic       result_valid,
  input  logic       hit,
  input  logic       nearmiss,
  input  logic       miss,
  output logic       done,
  output logic [7:0] shot_count,
  output logic [2:0] hit_count,
  output logic [7:0] near_count
);

  localparam logic [3:0] XMAX = 4'(GRID_W - 1);
  localparam logic [3:0] YMAX = 4'(GRID_H - 1);
  localparam logic [4:0] GH   = 5'(GRID_H);
  localparam logic [2:0] TH   = 3'(TARGET_HITS);

  state_t     state, state_n;
  logic [3:0] cur_x, cur_x_n;
  logic [4:0] cur_y, cur_y_n;
  logic [3:0] anc_x, anc_x_n;
  logic [3:0] anc_y, anc_y_n;
  logic [2:0] nidx, nidx_n;
  logic       targeting, targeting_n;
  logic [3:0] x_n, y_n;
  logic [7:0] shot_n, near_n;
  logic [2:0] hit_n;

  logic [3:0] adv_x;
  logic [4:0] adv_y;
  logic [3:0] cand_x, cand_y;
  logic       cand_ok;
  dir_t       dir;
  logic [4:0] q_x, q_y;
  logic       q_shot;
  logic       bm_clear, bm_set;
  verdict_t   verdict;
  logic [7:0] shot_inc, near_inc;
  logic [2:0] hit_inc;

  shot_bitmap #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_bitmap (
    .clock     (clock),
    .reset     (reset),
    .clear     (bm_clear),
    .set_en    (bm_set),
    .set_x     (x),
    .set_y     (y),
    .query_x   (q_x),
    .query_y   (q_y),
    .query_shot(q_shot)
  );

  assign shot_valid = (state == FIRE) || (state == WAIT);
  assign done       = (state == DONE);

  // Next hunt cell in row-major order. Running off the last row leaves the
  // cursor at row GRID_H, which the hunt state reads as "sweep finished".
  always_comb begin
    adv_x = cur_x + 4'd1;
    adv_y = cur_y;
    if (cur_x == XMAX) begin
      adv_x = 4'd0;
      adv_y = cur_y + 5'd1;
    end
  end

  // Neighbour candidate around the anchor. Edge cells are rejected before
  // any arithmetic could wrap, so cand_x/cand_y only matter when cand_ok.
  always_comb begin
    dir     = dir_t'(nidx[1:0]);
    cand_x  = anc_x;
    cand_y  = anc_y;
    cand_ok = 1'b0;
    case (dir)
      EAST: begin
        cand_x  = anc_x + 4'd1;
        cand_ok = (anc_x != XMAX);
      end
      WEST: begin
        cand_x  = anc_x - 4'd1;
        cand_ok = (anc_x != 4'd0);
      end
      SOUTH: begin
        cand_y  = anc_y + 4'd1;
        cand_ok = (anc_y != YMAX);
      end
      NORTH: begin
        cand_y  = anc_y - 4'd1;
        cand_ok = (anc_y != 4'd0);
      end
      default: begin
        cand_ok = 1'b0;
      end
    endcase
  end

  // The bitmap is asked about whichever cell the current state is weighing:
  // the neighbour candidate while targeting, the hunt cursor otherwise.
  always_comb begin
    q_x = {1'b0, cur_x};
    q_y = cur_y;
    if (state == TARGET) begin
      q_x = {1'b0, cand_x};
      q_y = {1'b0, cand_y};
    end
  end

  // Saturating increments and the collapsed verdict used on accept.
  always_comb begin
    verdict  = decode_verdict(hit, nearmiss, miss);
    shot_inc = (shot_count == 8'hFF) ? shot_count : shot_count + 8'd1;
    near_inc = (near_count == 8'hFF) ? near_count : near_count + 8'd1;
    hit_inc  = (hit_count == 3'd7) ? hit_count : hit_count + 3'd1;
  end

  // Controller next-state logic. A shot is accepted in FIRE or WAIT on the
  // first cycle result_valid is high; results at any other time fall through
  // the default "hold" path and are ignored. 'targeting' remembers whether
  // the outstanding shot came from neighbour probing or from the hunt sweep.
  always_comb begin
    state_n     = state;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    anc_x_n     = anc_x;
    anc_y_n     = anc_y;
    nidx_n      = nidx;
    targeting_n = targeting;
    x_n         = x;
    y_n         = y;
    shot_n      = shot_count;
    hit_n       = hit_count;
    near_n      = near_count;
    bm_clear    = 1'b0;
    bm_set      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = HUNT;
          cur_x_n     = 4'd0;
          cur_y_n     = 5'd0;
          targeting_n = 1'b0;
          shot_n      = 8'd0;
          hit_n       = 3'd0;
          near_n      = 8'd0;
          bm_clear    = 1'b1;
        end
      end

      HUNT: begin
        if (cur_y >= GH) begin
          state_n = DONE;
        end else if (((cur_x[0] ^ cur_y[0]) == 1'b0) && !q_shot) begin
          x_n         = cur_x;
          y_n         = cur_y[3:0];
          targeting_n = 1'b0;
          state_n     = FIRE;
        end else begin
          cur_x_n = adv_x;
          cur_y_n = adv_y;
        end
      end

      FIRE, WAIT: begin
        if (result_valid) begin
          bm_set = 1'b1;
          shot_n = shot_inc;
          case (verdict)
            V_HIT: begin
              hit_n = hit_inc;
              if (hit_inc >= TH) begin
                state_n = DONE;
              end else if (targeting) begin
                state_n = HUNT;
                cur_x_n = adv_x;
                cur_y_n = adv_y;
              end else begin
                anc_x_n = x;
                anc_y_n = y;
                nidx_n  = 3'd0;
                state_n = TARGET;
              end
            end
            V_NEAR, V_MISS: begin
              if (verdict == V_NEAR) begin
                near_n = near_inc;
              end
              if (targeting) begin
                nidx_n  = nidx + 3'd1;
                state_n = TARGET;
              end else begin
                state_n = HUNT;
                cur_x_n = adv_x;
                cur_y_n = adv_y;
              end
            end
            default: begin
              state_n = state;
            end
          endcase
        end else if (state == FIRE) begin
          state_n = WAIT;
        end
      end

      TARGET: begin
        if (nidx == 3'd4) begin
          state_n = HUNT;
          cur_x_n = adv_x;
          cur_y_n = adv_y;
        end else if (!cand_ok || q_shot) begin
          nidx_n = nidx + 3'd1;
        end else begin
          x_n         = cand_x;
          y_n         = cand_y;
          targeting_n = 1'b1;
          state_n     = FIRE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register. Reset drops any outstanding shot immediately, so a
  // verdict arriving in the same cycle as reset is simply lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cur_x      <= 4'd0;
      cur_y      <= 5'd0;
      anc_x      <= 4'd0;
      anc_y      <= 4'd0;
      nidx       <= 3'd0;
      targeting  <= 1'b0;
      x          <= 4'd0;
      y          <= 4'd0;
      shot_count <= 8'd0;
      hit_count  <= 3'd0;
      near_count <= 8'd0;
    end else begin
      state      <= state_n;
      cur_x      <= cur_x_n;
      cur_y      <= cur_y_n;
      anc_x      <= anc_x_n;
      anc_y      <= anc_y_n;
      nidx       <= nidx_n;
      targeting  <= targeting_n;
      x          <= x_n;
      y          <= y_n;
      shot_count <= shot_n;
      hit_count  <= hit_n;
      near_count <= near_n;
    end
  end

endmodule

// File: tb/tb_battleship_shooter.sv
// tb_battleship_shooter
// Plays whole games against battleship_shooter with a responder that knows
// the fleet, and compares the shot sequence and tallies with a game-level
// model of the shooting strategy.
module tb_battleship_shooter;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int TH = 4;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic       shot_valid;
  logic       result_valid;
  logic       hit;
  logic       nearmiss;
  logic       miss;
  logic       done;
  logic [7:0] shot_count;
  logic [2:0] hit_count;
  logic [7:0] near_count;

  int vectors;
  int miscompares;

  bit occ[W*H];
  bit mshot[W*H];
  int exp_x[$];
  int exp_y[$];
  int m_hits;
  int m_nears;

  int got_x[$];
  int got_y[$];
  int gaps[$];
  int first_cyc;

  battleship_shooter #(
    .GRID_W(W),
    .GRID_H(H),
    .TARGET_HITS(TH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x           (x),
    .y           (y),
    .shot_valid  (shot_valid),
    .result_valid(result_valid),
    .hit         (hit),
    .nearmiss    (nearmiss),
    .miss        (miss),
    .done        (done),
    .shot_count  (shot_count),
    .hit_count   (hit_count),
    .near_count  (near_count)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Occupancy lookup that treats everything off the board as open water.
  function automatic bit occ_at(input int cx, input int cy);
    if (cx < 0 || cy < 0 || cx >= W || cy >= H) return 1'b0;
    return occ[cy*W+cx];
  endfunction

  // Responder's ruling on a cell: 0 hit, 1 nearmiss (touches a ship), 2 miss.
  function automatic int cell_class(input int cx, input int cy);
    if (occ_at(cx, cy)) return 0;
    if (occ_at(cx+1, cy) || occ_at(cx-1, cy) || occ_at(cx, cy+1) || occ_at(cx, cy-1)) return 1;
    return 2;
  endfunction

  // Records one shot of the reference game.
  task automatic model_fire(input int cx, input int cy, output int c);
    exp_x.push_back(cx);
    exp_y.push_back(cy);
    mshot[cy*W+cx] = 1'b1;
    c = cell_class(cx, cy);
    if (c == 0) m_hits++;
    if (c == 1) m_nears++;
  endtask

  // Reference game: sweep even-parity cells in reading order; after a fresh
  // hit try E, W, S, N of it until one of them hits; stop at TH hits.
  task automatic build_model();
    int c, c2, nx, ny;
    bit over;
    exp_x.delete();
    exp_y.delete();
    mshot = '{default: 1'b0};
    m_hits = 0;
    m_nears = 0;
    over = 1'b0;
    for (int cy = 0; cy < H && !over; cy++) begin
      for (int cx = 0; cx < W && !over; cx++) begin
        if (((cx + cy) % 2 == 0) && !mshot[cy*W+cx]) begin
          model_fire(cx, cy, c);
          if (c == 0) begin
            if (m_hits >= TH) begin
              over = 1'b1;
            end else begin
              for (int d = 0; d < 4 && !over; d++) begin
                nx = cx + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
                ny = cy + ((d == 2) ? 1 : (d == 3) ? -1 : 0);
                if (nx >= 0 && ny >= 0 && nx < W && ny < H && !mshot[ny*W+nx]) begin
                  model_fire(nx, ny, c2);
                  if (c2 == 0) begin
                    if (m_hits >= TH) over = 1'b1;
                    break;
                  end
                end
              end
            end
          end
        end
      end
    end
  endtask

  // Two random two-cell boats, horizontal or vertical, not overlapping.
  task automatic place_random_fleet();
    int placed, ori, ax, ay, bx, by;
    occ = '{default: 1'b0};
    placed = 0;
    while (placed < 2) begin
      ori = int'($urandom_range(1, 0));
      ax  = int'($urandom_range(W - 1 - ((ori == 0) ? 1 : 0), 0));
      ay  = int'($urandom_range(H - 1 - ((ori == 1) ? 1 : 0), 0));
      bx  = ax + ((ori == 0) ? 1 : 0);
      by  = ay + ((ori == 1) ? 1 : 0);
      if (!occ[ay*W+ax] && !occ[by*W+bx]) begin
        occ[ay*W+ax] = 1'b1;
        occ[by*W+bx] = 1'b1;
        placed++;
      end
    end
  endtask

  // Pulses start for one clock; returns at the negedge where start drops.
  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Responder: answers each shot after a random latency, checks that x/y
  // hold for the whole request and that shot_valid drops after the accept,
  // and optionally sprinkles stray results and ignored start pulses.
  // stop_at >= 0 abandons the game while that shot index is outstanding.
  task automatic run_game(input int lat_lo, input int lat_hi, input bit stray, input int stop_at);
    int cyc, cnt, last_acc, c;
    logic [3:0] hx, hy;
    bit in_win, just_acc, fin;
    got_x.delete();
    got_y.delete();
    gaps.delete();
    cyc = 0; cnt = 0; last_acc = 0; in_win = 1'b0; just_acc = 1'b0; fin = 1'b0;
    first_cyc = -1; hx = 4'd0; hy = 4'd0;
    while (!fin) begin
      @(negedge clock);
      cyc++;
      result_valid = 1'b0; hit = 1'b0; nearmiss = 1'b0; miss = 1'b0; start = 1'b0;
      if (just_acc) begin
        vectors++;
        if (shot_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL sv_drop: shot_valid=%b required 0", shot_valid);
        end
        just_acc = 1'b0;
      end
      if (done === 1'b1) begin
        fin = 1'b1;
      end else if (cyc > 6000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL timeout: game still running after %0d cycles, shots=%0d", cyc, got_x.size());
        fin = 1'b1;
      end else if (shot_valid === 1'b1) begin
        if (!in_win) begin
          in_win = 1'b1;
          hx = x;
          hy = y;
          got_x.push_back(int'(x));
          got_y.push_back(int'(y));
          if (first_cyc < 0) first_cyc = cyc;
          gaps.push_back(cyc - last_acc);
          cnt = (got_x.size() - 1 == stop_at) ? 1000 : int'($urandom_range(lat_hi, lat_lo));
        end else begin
          vectors++;
          if (x !== hx || y !== hy) begin
            miscompares++;
            $display("[TB] FAIL xy_hold: got (%0d,%0d) required (%0d,%0d)", x, y, hx, hy);
          end
          if (got_x.size() - 1 == stop_at) fin = 1'b1;
        end
        if (!fin) begin
          if (cnt == 0) begin
            c = cell_class(int'(hx), int'(hy));
            result_valid = 1'b1;
            if (c == 0) begin
              hit = 1'b1;
              nearmiss = 1'($urandom_range(1, 0));
              miss = 1'($urandom_range(1, 0));
            end else if (c == 1) begin
              nearmiss = 1'b1;
              miss = 1'($urandom_range(1, 0));
            end else begin
              miss = ($urandom_range(3, 0) != 0);
            end
            in_win = 1'b0;
            just_acc = 1'b1;
            last_acc = cyc;
          end else begin
            cnt--;
          end
          if (stray && $urandom_range(7, 0) == 0) start = 1'b1;
        end
      end else if (stray && $urandom_range(3, 0) == 0) begin
        result_valid = 1'b1;
        hit = 1'($urandom_range(1, 0));
        nearmiss = 1'($urandom_range(1, 0));
        miss = 1'($urandom_range(1, 0));
      end
    end
    result_valid = 1'b0; hit = 1'b0; nearmiss = 1'b0; miss = 1'b0; start = 1'b0;
  endtask

  // Reset values on every output.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    vectors += 7;
    if (x !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_x: got %0d required 0", x); end
    if (y !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_y: got %0d required 0", y); end
    if (shot_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sv: got %b required 0", shot_valid); end
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    if (shot_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_shots: got %0d required 0", shot_count); end
    if (hit_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_hits: got %0d required 0", hit_count); end
    if (near_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_nears: got %0d required 0", near_count); end
  endtask

  // No ships: checkerboard sweep of 50 distinct cells, first shot two
  // cycles after start, then done with no hits.
  task automatic test_empty_fleet();
    int ex[6] = '{0, 2, 4, 6, 8, 1};
    int ey[6] = '{0, 0, 0, 0, 0, 1};
    bit seen[W*H];
    occ = '{default: 1'b0};
    seen = '{default: 1'b0};
    build_model();
    do_start();
    run_game(1, 1, 1'b0, -1);
    vectors++;
    if (first_cyc != 1) begin miscompares++; $display("[TB] FAIL first_latency: got %0d cycles after start drop required 1", first_cyc); end
    for (int i = 0; i < 6 && i < got_x.size(); i++) begin
      vectors++;
      if (got_x[i] != ex[i] || got_y[i] != ey[i]) begin
        miscompares++;
        $display("[TB] FAIL empty_first[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_x[i], got_y[i], ex[i], ey[i]);
      end
    end
    for (int i = 0; i < got_x.size(); i++) begin
      vectors++;
      if (seen[got_y[i]*W+got_x[i]]) begin
        miscompares++;
        $display("[TB] FAIL empty_dup: shot %0d at (%0d,%0d) repeated, required unique", i, got_x[i], got_y[i]);
      end
      seen[got_y[i]*W+got_x[i]] = 1'b1;
    end
    vectors += 5;
    if (got_x.size() != 50) begin miscompares++; $display("[TB] FAIL empty_nshots: got %0d required 50", got_x.size()); end
    if (exp_x.size() != got_x.size()) begin miscompares++; $display("[TB] FAIL empty_model_len: got %0d required %0d", got_x.size(), exp_x.size()); end
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL empty_done: got %b required 1", done); end
    if (shot_count !== 8'd50) begin miscompares++; $display("[TB] FAIL empty_shot_count: got %0d required 50", shot_count); end
    if (hit_count !== 3'd0) begin miscompares++; $display("[TB] FAIL empty_hit_count: got %0d required 0", hit_count); end
  endtask

  // Two horizontal boats at known places with random latency and stray
  // traffic; the shot order and counts follow the hand-worked game.
  task automatic test_boats();
    int ci[7] = '{8, 9, 10, 11, 48, 49, 50};
    int cx[7] = '{7, 8, 6, 9, 3, 4, 2};
    int cy[7] = '{1, 1, 1, 1, 9, 9, 9};
    occ = '{default: 1'b0};
    occ[9*W+2] = 1'b1; occ[9*W+3] = 1'b1;
    occ[1*W+6] = 1'b1; occ[1*W+7] = 1'b1;
    build_model();
    do_start();
    run_game(0, 7, 1'b1, -1);
    vectors++;
    if (got_x.size() != exp_x.size()) begin miscompares++; $display("[TB] FAIL boats_nshots: got %0d required %0d", got_x.size(), exp_x.size()); end
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        miscompares++;
        $display("[TB] FAIL boats_order[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (ci[k] >= got_x.size() || got_x[ci[k]] != cx[k] || got_y[ci[k]] != cy[k]) begin
        miscompares++;
        $display("[TB] FAIL boats_landmark[%0d]: shot missing or wrong, required (%0d,%0d)", ci[k], cx[k], cy[k]);
      end
    end
    vectors++;
    if (gaps.size() <= 9 || gaps[9] != 2) begin miscompares++; $display("[TB] FAIL boats_target_gap: east neighbour not issued 2 cycles after accept, required 2"); end
    vectors += 4;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL boats_done: got %b required 1", done); end
    if (shot_count !== 8'd51) begin miscompares++; $display("[TB] FAIL boats_shot_count: got %0d required 51", shot_count); end
    if (hit_count !== 3'd4) begin miscompares++; $display("[TB] FAIL boats_hit_count: got %0d required 4", hit_count); end
    if (near_count !== 8'(m_nears)) begin miscompares++; $display("[TB] FAIL boats_near_count: got %0d required %0d", near_count, m_nears); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      result_valid = 1'b1;
      hit = 1'($urandom_range(1, 0));
      nearmiss = 1'($urandom_range(1, 0));
      miss = 1'($urandom_range(1, 0));
    end
    @(negedge clock);
    result_valid = 1'b0; hit = 1'b0; nearmiss = 1'b0; miss = 1'b0;
    vectors += 3;
    if (shot_count !== 8'd51 || hit_count !== 3'd4) begin miscompares++; $display("[TB] FAIL done_frozen: shots=%0d hits=%0d required 51/4", shot_count, hit_count); end
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_sticky: got %b required 1", done); end
    if (shot_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL done_sv: got %b required 0", shot_valid); end
  endtask

  // Anchor on the right edge: the east candidate is skipped, so the west
  // shot comes one cycle later than an on-grid neighbour would.
  task automatic test_offgrid();
    occ = '{default: 1'b0};
    occ[1*W+8] = 1'b1; occ[1*W+9] = 1'b1;
    occ[5*W+0] = 1'b1; occ[5*W+1] = 1'b1;
    build_model();
    do_start();
    run_game(1, 1, 1'b0, -1);
    vectors += 3;
    if (got_x.size() <= 10 || got_x[9] != 9 || got_y[9] != 1) begin miscompares++; $display("[TB] FAIL edge_anchor: shot 9 missing or not (9,1), required (9,1)"); end
    if (got_x.size() <= 10 || got_x[10] != 8 || got_y[10] != 1) begin miscompares++; $display("[TB] FAIL edge_west: shot 10 missing or not (8,1), required (8,1)"); end
    if (gaps.size() <= 10 || gaps[10] != 3) begin miscompares++; $display("[TB] FAIL edge_gap: got %0d required 3", (gaps.size() > 10) ? gaps[10] : -1); end
    vectors++;
    if (got_x.size() != exp_x.size()) begin miscompares++; $display("[TB] FAIL edge_nshots: got %0d required %0d", got_x.size(), exp_x.size()); end
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        miscompares++;
        $display("[TB] FAIL edge_order[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  // Random fleets, random latency and stray traffic against the model.
  task automatic test_random();
    for (int g = 0; g < 4; g++) begin
      place_random_fleet();
      build_model();
      do_start();
      run_game(0, 7, 1'b1, -1);
      vectors++;
      if (got_x.size() != exp_x.size()) begin miscompares++; $display("[TB] FAIL rand%0d_nshots: got %0d required %0d", g, got_x.size(), exp_x.size()); end
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
        vectors++;
        if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_order[%0d]: got (%0d,%0d) required (%0d,%0d)", g, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
        end
      end
      vectors += 4;
      if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL rand%0d_done: got %b required 1", g, done); end
      if (shot_count !== 8'(exp_x.size())) begin miscompares++; $display("[TB] FAIL rand%0d_shot_count: got %0d required %0d", g, shot_count, exp_x.size()); end
      if (hit_count !== 3'(m_hits)) begin miscompares++; $display("[TB] FAIL rand%0d_hit_count: got %0d required %0d", g, hit_count, m_hits); end
      if (near_count !== 8'(m_nears)) begin miscompares++; $display("[TB] FAIL rand%0d_near_count: got %0d required %0d", g, near_count, m_nears); end
    end
  endtask

  // Reset while shot 5 is outstanding, then replay a clean game from (0,0).
  task automatic test_reset_midshot();
    occ = '{default: 1'b0};
    build_model();
    do_start();
    run_game(1, 3, 1'b0, 4);
    vectors++;
    if (shot_valid !== 1'b1 || got_x.size() != 5) begin miscompares++; $display("[TB] FAIL mid_setup: sv=%b shots=%0d required 1/5", shot_valid, got_x.size()); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors += 5;
    if (shot_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_sv: got %b required 0", shot_valid); end
    if (x !== 4'd0 || y !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_xy: got (%0d,%0d) required (0,0)", x, y); end
    if (shot_count !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_shots: got %0d required 0", shot_count); end
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done: got %b required 0", done); end
    if (hit_count !== 3'd0 || near_count !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_counts: got %0d/%0d required 0/0", hit_count, near_count); end
    do_start();
    run_game(0, 7, 1'b1, -1);
    vectors += 2;
    if (got_x.size() != exp_x.size()) begin miscompares++; $display("[TB] FAIL replay_nshots: got %0d required %0d", got_x.size(), exp_x.size()); end
    if (shot_count !== 8'd50) begin miscompares++; $display("[TB] FAIL replay_shot_count: got %0d required 50", shot_count); end
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        miscompares++;
        $display("[TB] FAIL replay_order[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  // Scenario sequence and final summary.
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;
    nearmiss = 1'b0;
    miss = 1'b0;
    test_reset();
    test_empty_fleet();
    test_boats();
    test_offgrid();
    test_random();
    test_reset_midshot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
